// File: rtl/count_stream_decoder.sv
// count_stream_decoder
//   Monitors a sampled counter bus, classifies each step (hold/up/down/jump),
//   locks onto a stepping mode once LOCK_COUNT identical steps are seen, and
//   flags/counts steps that break an established lock.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sample_valid count_in carries a new sample this cycle
//   count_in     counter value being decoded
//   mode         last locked mode: 0 hold, 1 up, 2 down
//   locked       high while locked
//   mode_change  one-cycle pulse on every entry to lock
//   step_error   one-cycle pulse on a step that breaks lock
//   err_count    saturating tally of step_error pulses
module count_stream_decoder #(
  parameter int WIDTH      = 5,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     count_in,
  output logic [1:0]           mode,
  output logic                 locked,
  output logic                 mode_change,
  output logic                 step_error,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  // Step classes share the mode encoding; JUMP doubles as "no candidate".
  localparam logic [1:0] C_HOLD = 2'd0;
  localparam logic [1:0] C_UP   = 2'd1;
  localparam logic [1:0] C_DOWN = 2'd2;
  localparam logic [1:0] C_JUMP = 2'd3;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  logic [1:0]           state, state_d;
  logic [1:0]           cand, cand_d;
  logic [3:0]           streak, streak_d;
  logic [WIDTH-1:0]     prev, prev_d;
  logic [1:0]           mode_d;
  logic                 locked_d, mc_d, se_d;
  logic [ERR_WIDTH-1:0] err_d;
  logic [WIDTH-1:0]     diff;
  logic [1:0]           cls;
  logic                 acq_eval;

  always_comb begin
    diff = count_in - prev;
    if (diff == '0)
      cls = C_HOLD;
    else if (diff == WIDTH'(1))
      cls = C_UP;
    else if (diff == '1)
      cls = C_DOWN;
    else
      cls = C_JUMP;
  end

  always_comb begin
    state_d  = state;
    cand_d   = cand;
    streak_d = streak;
    prev_d   = prev;
    mode_d   = mode;
    locked_d = locked;
    mc_d     = 1'b0;
    se_d     = 1'b0;
    err_d    = err_count;
    acq_eval = 1'b0;

    if (sample_valid) begin
      prev_d = count_in;
      case (state)
        S_IDLE: begin
          state_d  = S_ACQUIRE;
          cand_d   = C_JUMP;
          streak_d = '0;
        end
        S_ACQUIRE: begin
          acq_eval = 1'b1;
          if (cls == C_JUMP) begin
            cand_d   = C_JUMP;
            streak_d = '0;
          end else if (cls == cand) begin
            streak_d = streak + 4'd1;
          end else begin
            cand_d   = cls;
            streak_d = 4'd1;
          end
        end
        S_LOCKED: begin
          if (cls != mode) begin
            se_d     = 1'b1;
            locked_d = 1'b0;
            state_d  = S_ACQUIRE;
            acq_eval = 1'b1;
            if (err_count != '1)
              err_d = err_count + ERR_WIDTH'(1);
            if (cls == C_JUMP) begin
              cand_d   = C_JUMP;
              streak_d = '0;
            end else begin
              cand_d   = cls;
              streak_d = 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Lock test runs on the post-update streak, so a break out of LOCKED
      // can re-lock on the same edge when LOCK_COUNT is 1.
      if (acq_eval && streak_d == LOCK_N) begin
        state_d  = S_LOCKED;
        mode_d   = cand_d;
        locked_d = 1'b1;
        mc_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cand        <= C_JUMP;
      streak      <= '0;
      prev        <= '0;
      mode        <= '0;
      locked      <= 1'b0;
      mode_change <= 1'b0;
      step_error  <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_d;
      cand        <= cand_d;
      streak      <= streak_d;
      prev        <= prev_d;
      mode        <= mode_d;
      locked      <= locked_d;
      mode_change <= mc_d;
      step_error  <= se_d;
      err_count   <= err_d;
    end
  end

endmodule

// File: tb/tb_count_stream_decoder.sv
// tb_count_stream_decoder
//   Directed stimulus for count_stream_decoder (WIDTH=5, LOCK_COUNT=3,
//   ERR_WIDTH=8) checked every cycle against a history-based reference model,
//   plus hand-computed literal expectations at key points.
module tb_count_stream_decoder;
  localparam int W  = 5;
  localparam int L  = 3;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [W-1:0]  count_in = '0;
  logic [1:0]    mode;
  logic          locked, mode_change, step_error;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  count_stream_decoder #(.WIDTH(W), .LOCK_COUNT(L), .ERR_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .count_in(count_in),
    .mode(mode), .locked(locked), .mode_change(mode_change),
    .step_error(step_error), .err_count(err_count)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the list of step classes seen since acquisition
  // began and locks when the last L entries agree on a non-jump class.
  int m_mode, m_locked, m_mc, m_se, m_err, m_primed, m_prev, m_c;
  int hist[$];

  function automatic int classify(input int x, input int p);
    int d;
    d = (x - p + 32) % 32;
    if (d == 0) return 0;
    if (d == 1) return 1;
    if (d == 31) return 2;
    return 3;
  endfunction

  function automatic bit run_of(input int c);
    if (c == 3 || hist.size() < L) return 1'b0;
    for (int i = hist.size() - L; i < hist.size(); i++)
      if (hist[i] != c) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_locked = 0; m_mc = 0; m_se = 0; m_err = 0;
      m_primed = 0; m_prev = 0;
      hist.delete();
    end else begin
      m_mc = 0;
      m_se = 0;
      if (sample_valid) begin
        if (m_primed == 0) begin
          m_primed = 1;
        end else begin
          m_c = classify(int'(count_in), m_prev);
          if (m_locked != 0) begin
            if (m_c != m_mode) begin
              m_se = 1;
              if (m_err < 255) m_err++;
              m_locked = 0;
              hist.delete();
              hist.push_back(m_c);
            end
          end else begin
            hist.push_back(m_c);
          end
          if (m_locked == 0 && run_of(m_c)) begin
            m_locked = 1;
            m_mode = m_c;
            m_mc = 1;
            hist.delete();
          end
        end
        m_prev = int'(count_in);
      end
    end
  end

  always @(negedge clk) begin
    check("mode", 32'(mode), m_mode);
    check("locked", 32'(locked), m_locked);
    check("mode_change", 32'(mode_change), m_mc);
    check("step_error", 32'(step_error), m_se);
    check("err_count", 32'(err_count), m_err);
  end

  task automatic put(input int v);
    sample_valid = 1'b1;
    count_in = W'(v);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_locked", 32'(locked), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_err", 32'(err_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int p;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("init_locked", 32'(locked), 0);
    check("init_err", 32'(err_count), 0);
    rst_n = 1'b1;

    // 1: simple up lock
    put(4); put(5); put(6);
    check("t1_not_yet", 32'(locked), 0);
    put(7);
    check("t1_locked", 32'(locked), 1);
    check("t1_mode", 32'(mode), 1);
    check("t1_mc", 32'(mode_change), 1);
    idle(1);
    check("t1_mc_pulse", 32'(mode_change), 0);

    // 2: wrap in both directions
    do_reset();
    put(29); put(30); put(31); put(0);
    check("t2_up_lock", 32'(locked), 1);
    put(1);
    check("t2_no_err", 32'(step_error), 0);
    do_reset();
    put(0); put(31); put(30); put(29);
    check("t2_down_lock", 32'(locked), 1);
    check("t2_down_mode", 32'(mode), 2);

    // 3: reversal breaks lock, relocks down
    do_reset();
    put(7); put(8); put(9); put(10);
    put(9);
    check("t3_se", 32'(step_error), 1);
    check("t3_err", 32'(err_count), 1);
    check("t3_unlock", 32'(locked), 0);
    check("t3_mode_kept", 32'(mode), 1);
    put(8); put(7);
    check("t3_relock", 32'(mode), 2);
    check("t3_mc", 32'(mode_change), 1);

    // 4: jump breaks lock, three further steps relock
    do_reset();
    put(2); put(3); put(4); put(5);
    put(20);
    check("t4_se", 32'(step_error), 1);
    put(21); put(22);
    check("t4_no_lock", 32'(locked), 0);
    put(23);
    check("t4_relock", 32'(locked), 1);

    // 5: hold lock with gaps between samples
    do_reset();
    put(12); idle(3); put(12); idle(3); put(12); idle(3);
    check("t5_not_yet", 32'(locked), 0);
    put(12);
    check("t5_locked", 32'(locked), 1);
    check("t5_mode", 32'(mode), 0);
    idle(3);

    // 6: async reset mid-lock, priming after release, error saturation
    put(4); put(5); put(6); put(7);
    check("t6_pre_lock", 32'(locked), 1);
    do_reset();
    put(10); put(11); put(12);
    check("t6_prime_only", 32'(locked), 0);
    put(13);
    check("t6_relock", 32'(locked), 1);
    p = 13;
    for (int i = 0; i < 300; i++) begin
      p = (p + 10) % 32; put(p);
      p = (p + 1) % 32;  put(p);
      p = (p + 1) % 32;  put(p);
      p = (p + 1) % 32;  put(p);
    end
    check("t6_sat", 32'(err_count), 255);
    check("t6_locked", 32'(locked), 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
